lcd_ctrl_gen: RTL and testbench

Parametrised successor of the 8×8 LCD image controller. After reset it loads a `IMG_W`×`IMG_H` image from the image ROM into an internal pixel buffer. It then applies host commands to a 2×2 operation window and, on a write command, streams the whole buffer into the image RAM buffer (IRB). Compared with the fixed 8×8 controller it adds generic image and pixel sizes, a 4-bit command set with max/min/rotate/recentre, and restartable write.

---
 rtl/lcd_ctrl_pkg.sv | 40 ++++
 rtl/lcd_win_alu.sv | 87 ++++++++
 rtl/lcd_ctrl_gen.sv | 198 +++++++++++++++++++
 tb/tb_lcd_ctrl_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the generic LCD image controller: command codes,
// controller states and a constant-width helper.
package lcd_ctrl_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE    = 4'd0,
        CMD_UP       = 4'd1,
        CMD_DOWN     = 4'd2,
        CMD_LEFT     = 4'd3,
        CMD_RIGHT    = 4'd4,
        CMD_AVG      = 4'd5,
        CMD_MIRROR_X = 4'd6,
        CMD_MIRROR_Y = 4'd7,
        CMD_MAX      = 4'd8,
        CMD_MIN      = 4'd9,
        CMD_ROT_CCW  = 4'd10,
        CMD_ROT_CW   = 4'd11,
        CMD_RECENTRE = 4'd12,
        CMD_NOP13    = 4'd13,
        CMD_NOP14    = 4'd14,
        CMD_NOP15    = 4'd15
    } cmd_e;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_IDLE,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Bits needed to index 'value' items; never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) width++;
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: takes the four window pixels and an
// opcode and returns the four replacement pixels.
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int DW = 8
) (
    input  cmd_e          op,
    input  logic [DW-1:0] tl_i,
    input  logic [DW-1:0] tr_i,
    input  logic [DW-1:0] bl_i,
    input  logic [DW-1:0] br_i,
    output logic [DW-1:0] tl_o,
    output logic [DW-1:0] tr_o,
    output logic [DW-1:0] bl_o,
    output logic [DW-1:0] br_o
);

    logic [DW+1:0] sum;
    logic [DW-1:0] avg;
    logic [DW-1:0] max_top, max_bot, max_all;
    logic [DW-1:0] min_top, min_bot, min_all;

    always_comb begin
        sum     = (DW+2)'(tl_i) + (DW+2)'(tr_i) + (DW+2)'(bl_i) + (DW+2)'(br_i);
        avg     = DW'(sum >> 2);
        max_top = (tl_i > tr_i) ? tl_i : tr_i;
        max_bot = (bl_i > br_i) ? bl_i : br_i;
        max_all = (max_top > max_bot) ? max_top : max_bot;
        min_top = (tl_i < tr_i) ? tl_i : tr_i;
        min_bot = (bl_i < br_i) ? bl_i : br_i;
        min_all = (min_top < min_bot) ? min_top : min_bot;

        // NOTE: every output gets a default before the case so no latch is inferred.
        tl_o = tl_i;
        tr_o = tr_i;
        bl_o = bl_i;
        br_o = br_i;

        case (op)
            CMD_AVG: begin
                tl_o = avg;
                tr_o = avg;
                bl_o = avg;
                br_o = avg;
            end
            CMD_MIRROR_X: begin
                tl_o = bl_i;
                tr_o = br_i;
                bl_o = tl_i;
                br_o = tr_i;
            end
            CMD_MIRROR_Y: begin
                tl_o = tr_i;
                tr_o = tl_i;
                bl_o = br_i;
                br_o = bl_i;
            end
            CMD_MAX: begin
                tl_o = max_all;
                tr_o = max_all;
                bl_o = max_all;
                br_o = max_all;
            end
            CMD_MIN: begin
                tl_o = min_all;
                tr_o = min_all;
                bl_o = min_all;
                br_o = min_all;
            end
            CMD_ROT_CCW: begin
                tl_o = tr_i;
                tr_o = br_i;
                br_o = bl_i;
                bl_o = tl_i;
            end
            CMD_ROT_CW: begin
                tl_o = bl_i;
                bl_o = br_i;
                br_o = tr_i;
                tr_o = tl_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// Generic LCD image controller: loads an IMG_W x IMG_H image from ROM, edits a
// 2x2 window on host command and streams the whole image to the IRB on WRITE.
module lcd_ctrl_gen
    import lcd_ctrl_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int AW    = clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [AW-1:0] IRB_A,
    output logic [DW-1:0] IRB_D,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int RW = clog2(IMG_H);
    localparam int CW = clog2(IMG_W);

    localparam logic [RW-1:0] ROW_CTR  = RW'(IMG_H / 2);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_CTR  = CW'(IMG_W / 2);
    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [AW:0]   CNT_N    = (AW+1)'(N);
    localparam logic [AW:0]   CNT_LAST = (AW+1)'(N + 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(N - 1);

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    cmd_e          op_q, op_d;
    logic          rom_en_q, rom_en_d;
    logic [AW-1:0] rom_a_q, rom_a_d;
    logic          irb_rw_q, irb_rw_d;
    logic [AW-1:0] irb_a_q, irb_a_d;
    logic [DW-1:0] irb_d_q, irb_d_d;

    logic [DW-1:0] pix_mem [N];

    logic          load_we, exec_we;
    logic [AW-1:0] load_idx, irb_a_nxt;
    logic [AW-1:0] idx_tl, idx_tr, idx_bl, idx_br;
    logic [DW-1:0] new_tl, new_tr, new_bl, new_br;

    function automatic logic [AW-1:0] pix_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(int'(r) * IMG_W + int'(c));
    endfunction

    always_comb begin
        idx_tl    = pix_idx(row_q - RW'(1), col_q - CW'(1));
        idx_tr    = pix_idx(row_q - RW'(1), col_q);
        idx_bl    = pix_idx(row_q, col_q - CW'(1));
        idx_br    = pix_idx(row_q, col_q);
        load_idx  = AW'(cnt_q - (AW+1)'(2));
        irb_a_nxt = irb_a_q + AW'(1);
    end

    lcd_win_alu #(.DW(DW)) u_alu (
        .op   (op_q),
        .tl_i (pix_mem[idx_tl]),
        .tr_i (pix_mem[idx_tr]),
        .bl_i (pix_mem[idx_bl]),
        .br_i (pix_mem[idx_br]),
        .tl_o (new_tl),
        .tr_o (new_tr),
        .bl_o (new_bl),
        .br_o (new_br)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        op_d     = op_q;
        rom_en_d = rom_en_q;
        rom_a_d  = rom_a_q;
        irb_rw_d = irb_rw_q;
        irb_a_d  = irb_a_q;
        irb_d_d  = irb_d_q;
        load_we  = 1'b0;
        exec_we  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // cnt_q-1 is the address on the bus; ROM data lags it by one cycle.
                cnt_d = cnt_q + (AW+1)'(1);
                if (cnt_q < CNT_N) begin
                    rom_en_d = 1'b0;
                    rom_a_d  = cnt_q[AW-1:0];
                end else begin
                    rom_en_d = 1'b1;
                end
                load_we = (cnt_q >= (AW+1)'(2));
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd == CMD_WRITE) begin
                        state_d  = ST_WRITE;
                        irb_rw_d = 1'b0;
                        irb_a_d  = '0;
                        irb_d_d  = pix_mem[0];
                    end else begin
                        state_d = ST_EXEC;
                        op_d    = cmd_e'(cmd);
                    end
                end
            end
            ST_EXEC: begin
                exec_we = 1'b1;
                state_d = ST_IDLE;
                case (op_q)
                    CMD_UP:       if (row_q > RW'(1)) row_d = row_q - RW'(1);
                    CMD_DOWN:     if (row_q < ROW_MAX) row_d = row_q + RW'(1);
                    CMD_LEFT:     if (col_q > CW'(1)) col_d = col_q - CW'(1);
                    CMD_RIGHT:    if (col_q < COL_MAX) col_d = col_q + CW'(1);
                    CMD_RECENTRE: begin
                        row_d = ROW_CTR;
                        col_d = COL_CTR;
                    end
                    default: ;
                endcase
            end
            ST_WRITE: begin
                if (irb_a_q == ADDR_MAX) begin
                    state_d  = ST_DONE;
                    irb_rw_d = 1'b1;
                end else begin
                    irb_a_d = irb_a_nxt;
                    irb_d_d = pix_mem[irb_a_nxt];
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            row_q    <= ROW_CTR;
            col_q    <= COL_CTR;
            op_q     <= CMD_NOP15;
            rom_en_q <= 1'b1;
            rom_a_q  <= '0;
            irb_rw_q <= 1'b1;
            irb_a_q  <= '0;
            irb_d_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            op_q     <= op_d;
            rom_en_q <= rom_en_d;
            rom_a_q  <= rom_a_d;
            irb_rw_q <= irb_rw_d;
            irb_a_q  <= irb_a_d;
            irb_d_q  <= irb_d_d;
        end
    end

    // NOTE: the pixel buffer has no reset; LOAD overwrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (load_we) pix_mem[load_idx] <= IROM_Q;
        if (exec_we) begin
            pix_mem[idx_tl] <= new_tl;
            pix_mem[idx_tr] <= new_tr;
            pix_mem[idx_bl] <= new_bl;
            pix_mem[idx_br] <= new_br;
        end
    end

    assign IROM_EN = rom_en_q;
    assign IROM_A  = rom_a_q;
    assign IRB_RW  = irb_rw_q;
    assign IRB_A   = irb_a_q;
    assign IRB_D   = irb_d_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Directed bench for lcd_ctrl_gen at default size with a ROM holding mem[i]=i
// and a behavioural IRB that records every write.
module tb_lcd_ctrl_gen;

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic [7:0] irom_q = 8'd0;
    logic       IROM_EN, IRB_RW, busy, done;
    logic [5:0] IROM_A, IRB_A;
    logic [7:0] IRB_D;

    lcd_ctrl_gen #(.IMG_W(8), .IMG_H(8), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .IROM_Q    (irom_q),
        .IROM_EN   (IROM_EN),
        .IROM_A    (IROM_A),
        .IRB_RW    (IRB_RW),
        .IRB_A     (IRB_A),
        .IRB_D     (IRB_D),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!IROM_EN) irom_q <= 8'(IROM_A);

    logic [7:0] irb_mem  [N];
    int         irb_pass [N];
    int         pass_id = 0;
    int         total_writes = 0;
    int         total_done = 0;
    int         high_writes = 0;

    always @(posedge clk) begin
        if (!IRB_RW) begin
            irb_mem[IRB_A]  <= IRB_D;
            irb_pass[IRB_A] <= pass_id;
            total_writes    <= total_writes + 1;
            if (IRB_A >= 6'd21) high_writes <= high_writes + 1;
        end
        if (done) total_done <= total_done + 1;
    end

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] exp_img [N];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_irom_en"}, IROM_EN, 1);
        check({tag, "_irom_a"}, IROM_A, 0);
        check({tag, "_irb_rw"}, IRB_RW, 1);
        check({tag, "_irb_a"}, IRB_A, 0);
        check({tag, "_irb_d"}, IRB_D, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    task automatic issue(input logic [3:0] c);
        wait_idle();
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called with reset low: releases it and checks the LOAD timeline.
    task automatic release_and_load(input string tag);
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t <= 65; t++) begin
            @(negedge clk);
            if (t == 0) begin
                check({tag, "_c0_irom_en"}, IROM_EN, 0);
                check({tag, "_c0_irom_a"}, IROM_A, 0);
            end
            if (t == 63) check({tag, "_c63_irom_a"}, IROM_A, 63);
            if (t == 64) begin
                check({tag, "_c64_irom_en"}, IROM_EN, 1);
                check({tag, "_c64_busy"}, busy, 1);
            end
            if (t == 65) check({tag, "_c65_busy"}, busy, 0);
        end
    endtask

    task automatic reset_and_load(input string tag);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        release_and_load(tag);
    endtask

    task automatic do_write(input string tag);
        int w0, d0, wcyc;
        bit seq_ok;
        pass_id++;
        w0     = total_writes;
        d0     = total_done;
        wcyc   = 0;
        seq_ok = 1'b1;
        issue(4'd0);
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                check({tag, "_done_busy"}, busy, 1);
                check({tag, "_done_irb_rw"}, IRB_RW, 1);
                @(negedge clk);
                check({tag, "_after_done_busy"}, busy, 0);
                check({tag, "_done_width"}, done, 0);
                break;
            end
            if (!IRB_RW) begin
                if (int'(IRB_A) != wcyc) seq_ok = 1'b0;
                wcyc++;
            end
            @(negedge clk);
        end
        check({tag, "_write_cycles"}, wcyc, 64);
        check({tag, "_addr_sequence_ok"}, seq_ok, 1);
        check({tag, "_irb_writes"}, total_writes - w0, 64);
        check({tag, "_done_pulses"}, total_done - d0, 1);
    endtask

    task automatic check_image(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++)
            if (irb_pass[i] != pass_id || irb_mem[i] !== exp_img[i]) bad++;
        check({tag, "_image_mismatches"}, bad, 0);
    endtask

    task automatic identity_image();
        for (int i = 0; i < N; i++) exp_img[i] = 8'(i);
    endtask

    // Commands are issued from nibble ncmd-1 down to nibble 0.
    typedef struct packed {
        logic [31:0] cmds;
        logic [3:0]  ncmd;
        logic [23:0] addrs;
        logic [31:0] vals;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [3:0] held_cmds [6];
        int w0, h0, d0;

        vecs[0]  = '{cmds: 32'h5,        ncmd: 4'd1, addrs: {6'd27, 6'd28, 6'd35, 6'd36}, vals: {8'd31, 8'd31, 8'd31, 8'd31}};
        vecs[1]  = '{cmds: 32'h333335,   ncmd: 4'd6, addrs: {6'd24, 6'd25, 6'd32, 6'd33}, vals: {8'd28, 8'd28, 8'd28, 8'd28}};
        vecs[2]  = '{cmds: 32'h6B,       ncmd: 4'd2, addrs: {6'd27, 6'd28, 6'd35, 6'd36}, vals: {8'd27, 8'd35, 8'd28, 8'd36}};
        vecs[3]  = '{cmds: 32'h7,        ncmd: 4'd1, addrs: {6'd27, 6'd28, 6'd35, 6'd36}, vals: {8'd28, 8'd27, 8'd36, 8'd35}};
        vecs[4]  = '{cmds: 32'h8,        ncmd: 4'd1, addrs: {6'd27, 6'd28, 6'd35, 6'd36}, vals: {8'd36, 8'd36, 8'd36, 8'd36}};
        vecs[5]  = '{cmds: 32'h9,        ncmd: 4'd1, addrs: {6'd27, 6'd28, 6'd35, 6'd36}, vals: {8'd27, 8'd27, 8'd27, 8'd27}};
        vecs[6]  = '{cmds: 32'hA,        ncmd: 4'd1, addrs: {6'd27, 6'd28, 6'd35, 6'd36}, vals: {8'd28, 8'd36, 8'd27, 8'd35}};
        vecs[7]  = '{cmds: 32'h11115,    ncmd: 4'd5, addrs: {6'd3,  6'd4,  6'd11, 6'd12}, vals: {8'd7,  8'd7,  8'd7,  8'd7}};
        vecs[8]  = '{cmds: 32'h22244448, ncmd: 4'd8, addrs: {6'd54, 6'd55, 6'd62, 6'd63}, vals: {8'd63, 8'd63, 8'd63, 8'd63}};
        vecs[9]  = '{cmds: 32'h4C9,      ncmd: 4'd3, addrs: {6'd27, 6'd28, 6'd35, 6'd36}, vals: {8'd27, 8'd27, 8'd27, 8'd27}};
        vecs[10] = '{cmds: 32'hDEF5,     ncmd: 4'd4, addrs: {6'd27, 6'd28, 6'd35, 6'd36}, vals: {8'd31, 8'd31, 8'd31, 8'd31}};

        // Power-on reset, load timeline, plain WRITE of the loaded image.
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("por");
        release_and_load("por_load");
        do_write("first_write");
        identity_image();
        check_image("first_write");

        for (int v = 0; v < 11; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            reset_and_load(tag);
            for (int k = int'(vecs[v].ncmd) - 1; k >= 0; k--) issue(vecs[v].cmds[k*4 +: 4]);
            identity_image();
            for (int j = 0; j < 4; j++)
                exp_img[vecs[v].addrs[(3-j)*6 +: 6]] = vecs[v].vals[(3-j)*8 +: 8];
            do_write(tag);
            check_image(tag);
            for (int j = 0; j < 4; j++)
                check($sformatf("%s_pix%0d", tag, int'(vecs[v].addrs[(3-j)*6 +: 6])),
                      irb_mem[vecs[v].addrs[(3-j)*6 +: 6]], vecs[v].vals[(3-j)*8 +: 8]);
        end

        // cmd_valid held high throughout; a WRITE code is offered in every busy cycle.
        reset_and_load("held");
        held_cmds[0] = 4'd8;
        held_cmds[1] = 4'd12;
        held_cmds[2] = 4'd9;
        held_cmds[3] = 4'd13;
        held_cmds[4] = 4'd14;
        held_cmds[5] = 4'd15;
        w0 = total_writes;
        for (int k = 0; k < 6; k++) begin
            wait_idle();
            cmd       = held_cmds[k];
            cmd_valid = 1'b1;
            @(negedge clk);
            check($sformatf("held_busy_after_cmd%0d", held_cmds[k]), busy, 1);
            cmd = 4'd0;
            @(negedge clk);
            check($sformatf("held_busy_one_cycle_cmd%0d", held_cmds[k]), busy, 0);
        end
        cmd_valid = 1'b0;
        check("held_no_stray_write", total_writes - w0, 0);
        identity_image();
        exp_img[27] = 8'd36;
        exp_img[28] = 8'd36;
        exp_img[35] = 8'd36;
        exp_img[36] = 8'd36;
        do_write("held");
        check_image("held");

        // Reset asserted mid-WRITE while address 20 is on the bus.
        reset_and_load("abort");
        pass_id++;
        w0 = total_writes;
        h0 = high_writes;
        d0 = total_done;
        issue(4'd0);
        for (int i = 0; i < 100; i++) begin
            if (!IRB_RW && IRB_A == 6'd20) break;
            @(negedge clk);
        end
        check("abort_reached_addr20", IRB_A, 20);
        reset = 1'b0;
        #1;
        check_reset_values("abort_async");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_writes_done", total_writes - w0, 20);
        check("abort_high_writes", high_writes - h0, 0);
        check("abort_no_done", total_done - d0, 0);
        release_and_load("abort_reload");
        do_write("abort_rewrite");
        identity_image();
        check_image("abort_rewrite");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
